// File: rtl/m_ext_ctrl_if.sv
// Bundle of signals between the M-extension controller, the EX stage and the
// shared multiplier/divider units.
interface m_ext_ctrl_if #(
  parameter int XLEN = 32
);
  // Handshake: an op is accepted in an IDLE cycle with req_valid=1 and flush=0.
  // stall_o then holds EX (req_valid stays stable) until the single cycle where
  // result_valid_o=1 and stall_o=0; unit start/done are one-cycle pulses.
  logic              req_valid;
  logic [2:0]        funct3;
  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b;
  logic              flush;

  logic              mul_start;
  logic              mul_a_signed;
  logic              mul_b_signed;
  logic [XLEN-1:0]   mul_a;
  logic [XLEN-1:0]   mul_b;
  logic              mul_done;
  logic [2*XLEN-1:0] mul_product;

  logic              div_start;
  logic              div_signed;
  logic [XLEN-1:0]   div_a;
  logic [XLEN-1:0]   div_b;
  logic              div_done;
  logic [XLEN-1:0]   div_quotient;
  logic [XLEN-1:0]   div_remainder;

  logic              stall_o;
  logic              result_valid_o;
  logic [XLEN-1:0]   result_o;

  modport master (
    input  req_valid, funct3, op_a, op_b, flush,
    input  mul_done, mul_product,
    input  div_done, div_quotient, div_remainder,
    output mul_start, mul_a_signed, mul_b_signed, mul_a, mul_b,
    output div_start, div_signed, div_a, div_b,
    output stall_o, result_valid_o, result_o
  );

  modport slave (
    output req_valid, funct3, op_a, op_b, flush,
    output mul_done, mul_product,
    output div_done, div_quotient, div_remainder,
    input  mul_start, mul_a_signed, mul_b_signed, mul_a, mul_b,
    input  div_start, div_signed, div_a, div_b,
    input  stall_o, result_valid_o, result_o
  );
endinterface

// File: rtl/m_ext_ctrl.sv
// RV32M sequencer: starts the shared multiplier or divider for an EX op, stalls
// until the result returns, and resolves divide-by-zero / overflow locally.
module m_ext_ctrl #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst,
  m_ext_ctrl_if.master bus,
  output logic [2:0]   state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MUL_BUSY = 3'd1,
    S_DIV_BUSY = 3'd2,
    S_DONE     = 3'd3,
    S_DRAIN    = 3'd4
  } state_e;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] mul_a_q, mul_a_d;
  logic [XLEN-1:0] mul_b_q, mul_b_d;
  logic [XLEN-1:0] div_a_q, div_a_d;
  logic [XLEN-1:0] div_b_q, div_b_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            mul_a_signed_q, mul_a_signed_d;
  logic            mul_b_signed_q, mul_b_signed_d;
  logic            div_signed_q, div_signed_d;
  logic            mul_start_q, mul_start_d;
  logic            div_start_q, div_start_d;

  logic            div_by_zero;
  logic            div_ovf;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] unit_res;
  logic            pend_done;
  logic            stall;
  logic            result_valid;

  // Divide special cases are resolved from the live EX operands at accept time.
  assign div_by_zero = (bus.op_b == '0);
  assign div_ovf     = ~bus.funct3[0] & (bus.op_a == INT_MIN) & (bus.op_b == '1);
  assign special_res = div_by_zero ? (bus.funct3[1] ? bus.op_a : '1)
                                   : (bus.funct3[1] ? '0 : INT_MIN);

  // funct3_q[2] identifies which unit owns the outstanding op (also in DRAIN).
  assign pend_done = funct3_q[2] ? bus.div_done : bus.mul_done;
  assign unit_res  = funct3_q[2] ? (funct3_q[1] ? bus.div_remainder : bus.div_quotient)
                                 : ((funct3_q[1:0] == 2'b00) ? bus.mul_product[XLEN-1:0]
                                                             : bus.mul_product[2*XLEN-1:XLEN]);

  always_comb begin
    state_d        = state_q;
    funct3_d       = funct3_q;
    mul_a_d        = mul_a_q;
    mul_b_d        = mul_b_q;
    div_a_d        = div_a_q;
    div_b_d        = div_b_q;
    result_d       = result_q;
    mul_a_signed_d = mul_a_signed_q;
    mul_b_signed_d = mul_b_signed_q;
    div_signed_d   = div_signed_q;
    mul_start_d    = 1'b0;
    div_start_d    = 1'b0;
    stall          = 1'b0;
    result_valid   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && !bus.flush) begin
          stall    = 1'b1;
          funct3_d = bus.funct3;
          if (!bus.funct3[2]) begin
            mul_a_d        = bus.op_a;
            mul_b_d        = bus.op_b;
            mul_a_signed_d = (bus.funct3[1:0] != 2'b11);
            mul_b_signed_d = ~bus.funct3[1];
            mul_start_d    = 1'b1;
            state_d        = S_MUL_BUSY;
          end else if (div_by_zero || div_ovf) begin
            result_d = special_res;
            state_d  = S_DONE;
          end else begin
            div_a_d      = bus.op_a;
            div_b_d      = bus.op_b;
            div_signed_d = ~bus.funct3[0];
            div_start_d  = 1'b1;
            state_d      = S_DIV_BUSY;
          end
        end
      end

      S_MUL_BUSY, S_DIV_BUSY: begin
        if (bus.flush) begin
          state_d = pend_done ? S_IDLE : S_DRAIN;
        end else begin
          stall = 1'b1;
          if (pend_done) begin
            result_d = unit_res;
            state_d  = S_DONE;
          end
        end
      end

      S_DONE: begin
        result_valid = ~bus.flush;
        state_d      = S_IDLE;
      end

      // Squashed op still owns its unit; hold off new work until it reports.
      S_DRAIN: begin
        stall = bus.req_valid & ~bus.flush;
        if (pend_done) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      funct3_q       <= '0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      div_a_q        <= '0;
      div_b_q        <= '0;
      result_q       <= '0;
      mul_a_signed_q <= 1'b0;
      mul_b_signed_q <= 1'b0;
      div_signed_q   <= 1'b0;
      mul_start_q    <= 1'b0;
      div_start_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      funct3_q       <= funct3_d;
      mul_a_q        <= mul_a_d;
      mul_b_q        <= mul_b_d;
      div_a_q        <= div_a_d;
      div_b_q        <= div_b_d;
      result_q       <= result_d;
      mul_a_signed_q <= mul_a_signed_d;
      mul_b_signed_q <= mul_b_signed_d;
      div_signed_q   <= div_signed_d;
      mul_start_q    <= mul_start_d;
      div_start_q    <= div_start_d;
    end
  end

  assign bus.mul_start      = mul_start_q;
  assign bus.mul_a_signed   = mul_a_signed_q;
  assign bus.mul_b_signed   = mul_b_signed_q;
  assign bus.mul_a          = mul_a_q;
  assign bus.mul_b          = mul_b_q;
  assign bus.div_start      = div_start_q;
  assign bus.div_signed     = div_signed_q;
  assign bus.div_a          = div_a_q;
  assign bus.div_b          = div_b_q;
  assign bus.stall_o        = stall;
  assign bus.result_valid_o = result_valid;
  assign bus.result_o       = result_q;
  assign state_o            = state_q;

endmodule

// File: tb/tb_m_ext_ctrl.sv
// Bench for m_ext_ctrl: latency-programmable multiplier/divider models plus a
// reference result model and scoreboard for directed and random RV32M ops.
module tb_m_ext_ctrl;

  localparam logic [31:0] MIN32 = 32'h8000_0000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] state_dbg;

  m_ext_ctrl_if #(.XLEN(32)) bus ();

  m_ext_ctrl #(.XLEN(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_dbg)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];

  // ---------------- unit models ----------------
  int   mul_lat = 4;
  int   div_lat = 33;
  int   mul_rem = 0;
  int   div_rem = 0;
  int   restart_err = 0;
  logic mul_done_r = 1'b0;
  logic div_done_r = 1'b0;
  logic stray_mul = 1'b0;
  logic stray_div = 1'b0;

  // Latency L: done is high in the (L-1)th cycle after the start cycle.
  always @(posedge clk) begin
    if (bus.mul_start) begin
      if (mul_rem > 0) restart_err <= restart_err + 1;
      mul_rem    <= mul_lat - 1;
      mul_done_r <= (mul_lat == 2);
    end else if (mul_rem > 0) begin
      mul_rem    <= mul_rem - 1;
      mul_done_r <= (mul_rem == 2);
    end else begin
      mul_done_r <= 1'b0;
    end
    if (bus.div_start) begin
      if (div_rem > 0) restart_err <= restart_err + 1;
      div_rem    <= div_lat - 1;
      div_done_r <= (div_lat == 2);
    end else if (div_rem > 0) begin
      div_rem    <= div_rem - 1;
      div_done_r <= (div_rem == 2);
    end else begin
      div_done_r <= 1'b0;
    end
  end

  assign bus.mul_done = mul_done_r | ((mul_lat == 1) & bus.mul_start) | stray_mul;
  assign bus.div_done = div_done_r | ((div_lat == 1) & bus.div_start) | stray_div;

  logic [63:0] mul_ea, mul_eb;
  assign mul_ea = bus.mul_a_signed ? {{32{bus.mul_a[31]}}, bus.mul_a} : {32'd0, bus.mul_a};
  assign mul_eb = bus.mul_b_signed ? {{32{bus.mul_b[31]}}, bus.mul_b} : {32'd0, bus.mul_b};
  assign bus.mul_product = mul_ea * mul_eb;

  always_comb begin
    if (bus.div_b == 32'd0) begin
      bus.div_quotient  = '1;
      bus.div_remainder = bus.div_a;
    end else if (bus.div_signed && bus.div_a == MIN32 && bus.div_b == '1) begin
      bus.div_quotient  = MIN32;
      bus.div_remainder = '0;
    end else if (bus.div_signed) begin
      bus.div_quotient  = $signed(bus.div_a) / $signed(bus.div_b);
      bus.div_remainder = $signed(bus.div_a) % $signed(bus.div_b);
    end else begin
      bus.div_quotient  = bus.div_a / bus.div_b;
      bus.div_remainder = bus.div_a % bus.div_b;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ua = longint'({32'd0, a});
    longint      ub = longint'({32'd0, b});
    logic [63:0] t;
    case (f3)
      3'b000: begin t = sa * sb; return t[31:0]; end
      3'b001: begin t = sa * sb; return t[63:32]; end
      3'b010: begin t = sa * ub; return t[63:32]; end
      3'b011: begin t = ua * ub; return t[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN32 && b == 32'hFFFF_FFFF) return MIN32;
        t = sa / sb; return t[31:0];
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        t = ua / ub; return t[31:0];
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == MIN32 && b == 32'hFFFF_FFFF) return 32'd0;
        t = sa % sb; return t[31:0];
      end
      default: begin
        if (b == 0) return a;
        t = ua % ub; return t[31:0];
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      check("idle_valid", bus.result_valid_o, 1'b0);
      check("idle_stall", bus.stall_o, 1'b0);
      check("idle_mul_start", bus.mul_start, 1'b0);
      @(negedge clk);
    end
  endtask

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input int extra);
    int   stalls = 0;
    int   mul_st = 0;
    int   div_st = 0;
    int   cyc = 0;
    bit   got = 0;
    bit   is_div;
    bit   special;
    bit   exp_as;
    bit   exp_bs;
    bit   exp_ds;
    int   exp_stall;
    is_div  = (f3 >= 3'b100);
    special = is_div && (b == 0 || ((f3 == 3'b100 || f3 == 3'b110) && a == MIN32 && b == '1));
    exp_as  = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
    exp_bs  = (f3 == 3'b000 || f3 == 3'b001);
    exp_ds  = (f3 == 3'b100 || f3 == 3'b110);
    exp_stall = special ? 1 : ((is_div ? div_lat : mul_lat) + 1 + extra);
    exp_q.push_back(ref_result(f3, a, b));
    bus.req_valid = 1'b1;
    bus.funct3    = f3;
    bus.op_a      = a;
    bus.op_b      = b;
    while (!got && cyc < 300) begin
      #1;
      if (bus.stall_o) stalls++;
      if (bus.mul_start) begin
        mul_st++;
        check("mul_a_signed", bus.mul_a_signed, exp_as);
        check("mul_b_signed", bus.mul_b_signed, exp_bs);
        check("mul_a", bus.mul_a, a);
        check("mul_b", bus.mul_b, b);
      end
      if (bus.div_start) begin
        div_st++;
        check("div_signed", bus.div_signed, exp_ds);
        check("div_a", bus.div_a, a);
        check("div_b", bus.div_b, b);
      end
      if (bus.result_valid_o) begin
        got = 1;
        check("stall_at_valid", bus.stall_o, 1'b0);
        if (exp_q.size() > 0) check($sformatf("result_f%0d", f3), bus.result_o, exp_q.pop_front());
        else check("extra_result", exp_q.size(), 1);
      end
      @(negedge clk);
      cyc++;
    end
    check("op_completed", got, 1'b1);
    if (!got && exp_q.size() > 0) void'(exp_q.pop_front());
    check("stall_cycles", stalls, exp_stall);
    check("mul_starts", mul_st, (is_div ? 0 : 1));
    check("div_starts", div_st, ((is_div && !special) ? 1 : 0));
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return MIN32;
      3:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    bus.req_valid = 1'b0;
    bus.funct3    = 3'b000;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.flush     = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_stall", bus.stall_o, 1'b0);
    check("rst_valid", bus.result_valid_o, 1'b0);
    check("rst_result", bus.result_o, 32'd0);
    check("rst_mul_start", bus.mul_start, 1'b0);
    check("rst_div_start", bus.div_start, 1'b0);
    check("rst_mul_a", bus.mul_a, 32'd0);
    check("rst_div_b", bus.div_b, 32'd0);
    rst = 1'b0;
    idle(2);

    // Directed multiplies and divides.
    mul_lat = 4;
    do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 0);
    idle(1);
    do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(3'b010, 32'hFFFF_FFFF, 32'd2, 0);
    idle(1);
    do_op(3'b100, 32'd5, 32'd0, 0);
    do_op(3'b111, 32'd5, 32'd0, 0);
    do_op(3'b100, MIN32, 32'hFFFF_FFFF, 0);
    do_op(3'b110, MIN32, 32'hFFFF_FFFF, 0);
    div_lat = 33;
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 0);
    idle(1);

    // Flush in the third busy cycle of a divide, next op waits for div_done.
    bus.req_valid = 1'b1;
    bus.funct3    = 3'b100;
    bus.op_a      = 32'hFFFF_FFF9;
    bus.op_b      = 32'd2;
    #1 check("fl_accept_stall", bus.stall_o, 1'b1);
    @(negedge clk);
    #1 check("fl_div_start", bus.div_start, 1'b1);
    @(negedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    #1;
    check("fl_stall", bus.stall_o, 1'b0);
    check("fl_valid", bus.result_valid_o, 1'b0);
    @(negedge clk);
    bus.flush = 1'b0;
    do_op(3'b000, 32'd6, 32'd9, 30);
    idle(1);

    // A request coinciding with flush in IDLE is not accepted.
    bus.req_valid = 1'b1;
    bus.funct3    = 3'b000;
    bus.op_a      = 32'd3;
    bus.op_b      = 32'd3;
    bus.flush     = 1'b1;
    #1 check("idle_flush_stall", bus.stall_o, 1'b0);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.req_valid = 1'b0;
    #1 check("idle_flush_no_start", bus.mul_start, 1'b0);
    @(negedge clk);

    // Back-to-back MUL then DIVU with req_valid held high.
    mul_lat = 3;
    div_lat = 6;
    do_op(3'b000, 32'd1234, 32'd5678, 0);
    do_op(3'b101, 32'd1000, 32'd7, 0);
    idle(2);

    // Reset mid-multiply; the unit's late done lands in IDLE and is ignored.
    mul_lat = 8;
    bus.req_valid = 1'b1;
    bus.funct3    = 3'b000;
    bus.op_a      = 32'd3;
    bus.op_b      = 32'd5;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_result", bus.result_o, 32'd0);
    idle(10);
    stray_div = 1'b1;
    #1 check("stray_div_valid", bus.result_valid_o, 1'b0);
    @(negedge clk);
    stray_div = 1'b0;
    idle(2);

    // Randomized ops with random unit latencies.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      f3      = 3'($urandom_range(0, 7));
      a       = pick_operand();
      b       = pick_operand();
      mul_lat = $urandom_range(1, 6);
      div_lat = $urandom_range(1, 12);
      do_op(f3, a, b, 0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    idle(3);
    check("exp_q_empty", exp_q.size(), 0);
    check("no_unit_restart", restart_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
